// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: holds the fetch PC, issues one I-cache request at a time and
// writes each returned instruction pair (with TLB fault flags) into the instruction FIFO.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_full,
  output logic        inst_req,
  output logic [31:0] inst_vaddr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  input  logic        inst_tlb_refill,
  input  logic        inst_tlb_invalid,
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2,
  output logic        write_tlb_refill1,
  output logic        write_tlb_refill2,
  output logic        write_tlb_invalid1,
  output logic        write_tlb_invalid2
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CANCEL = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        wen1_q, wen1_d;
  logic        wen2_q, wen2_d;
  logic [31:0] waddr1_q, waddr1_d;
  logic [31:0] waddr2_q, waddr2_d;
  logic [31:0] wdata1_q, wdata1_d;
  logic [31:0] wdata2_q, wdata2_d;
  logic        wrefill1_q, wrefill1_d;
  logic        winvalid1_q, winvalid1_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_next_pair;
  logic        fault;
  logic        pair_ok;
  logic        capture;

  assign pc_plus4     = pc_q + 32'd4;
  assign pc_next_pair = {pc_q[31:3] + 29'd1, 3'b000};
  assign fault        = inst_tlb_refill | inst_tlb_invalid;
  // A faulting response or an odd-word PC yields only the first slot.
  assign pair_ok      = ~pc_q[2] & ~fault;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (!fifo_full) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = inst_addr_ok ? ST_CANCEL : ST_IDLE;
        end else if (inst_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = inst_data_ok ? ST_IDLE : ST_CANCEL;
        end else if (inst_data_ok) begin
          capture = 1'b1;
          if (fault) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_next_pair;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CANCEL: begin
        // The single outstanding response is swallowed here; redirects keep updating pc.
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (inst_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wen1_d      = 1'b0;
    wen2_d      = 1'b0;
    waddr1_d    = 32'd0;
    waddr2_d    = 32'd0;
    wdata1_d    = 32'd0;
    wdata2_d    = 32'd0;
    wrefill1_d  = 1'b0;
    winvalid1_d = 1'b0;
    if (capture) begin
      wen1_d      = 1'b1;
      waddr1_d    = pc_q;
      wdata1_d    = inst_rdata1;
      wrefill1_d  = inst_tlb_refill;
      winvalid1_d = inst_tlb_invalid;
      if (pair_ok) begin
        wen2_d   = 1'b1;
        waddr2_d = pc_plus4;
        wdata2_d = inst_rdata2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      wen1_q      <= 1'b0;
      wen2_q      <= 1'b0;
      waddr1_q    <= 32'd0;
      waddr2_q    <= 32'd0;
      wdata1_q    <= 32'd0;
      wdata2_q    <= 32'd0;
      wrefill1_q  <= 1'b0;
      winvalid1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wen1_q      <= wen1_d;
      wen2_q      <= wen2_d;
      waddr1_q    <= waddr1_d;
      waddr2_q    <= waddr2_d;
      wdata1_q    <= wdata1_d;
      wdata2_q    <= wdata2_d;
      wrefill1_q  <= wrefill1_d;
      winvalid1_q <= winvalid1_d;
    end
  end

  assign inst_req   = (state_q == ST_REQ);
  assign inst_vaddr = pc_q;

  // A redirect arriving with the registered write kills it, since the FIFO is flushed too.
  assign write_en1          = wen1_q & ~redirect_valid;
  assign write_en2          = wen2_q & ~redirect_valid;
  assign write_address1     = waddr1_q;
  assign write_address2     = waddr2_q;
  assign write_data1        = wdata1_q;
  assign write_data2        = wdata2_q;
  assign write_tlb_refill1  = wrefill1_q;
  assign write_tlb_invalid1 = winvalid1_q;
  assign write_tlb_refill2  = 1'b0;
  assign write_tlb_invalid2 = 1'b0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then random traffic, checked by a
// transaction-level model feeding a scoreboard of expected FIFO writes.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fifo_full = 1'b0;
  logic        inst_req;
  logic [31:0] inst_vaddr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata1 = 32'd0;
  logic [31:0] inst_rdata2 = 32'd0;
  logic        inst_tlb_refill = 1'b0;
  logic        inst_tlb_invalid = 1'b0;
  logic        write_en1, write_en2;
  logic [31:0] write_address1, write_address2;
  logic [31:0] write_data1, write_data2;
  logic        write_tlb_refill1, write_tlb_refill2;
  logic        write_tlb_invalid1, write_tlb_invalid2;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fifo_full(fifo_full),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata1(inst_rdata1), .inst_rdata2(inst_rdata2),
    .inst_tlb_refill(inst_tlb_refill), .inst_tlb_invalid(inst_tlb_invalid),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_address1(write_address1), .write_address2(write_address2),
    .write_data1(write_data1), .write_data2(write_data2),
    .write_tlb_refill1(write_tlb_refill1), .write_tlb_refill2(write_tlb_refill2),
    .write_tlb_invalid1(write_tlb_invalid1), .write_tlb_invalid2(write_tlb_invalid2)
  );

  typedef struct {
    bit          en1;
    bit          en2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] d1;
    logic [31:0] d2;
    bit          rf1;
    bit          iv1;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  // Reference model state: fetch pc, whether a request is in flight and still wanted,
  // halted after a fault, and whether a request should be visible this cycle.
  bit          model_valid = 1'b0;
  bit          exp_req = 1'b0;
  bit          m_out = 1'b0;
  bit          m_live = 1'b0;
  bit          m_halt = 1'b0;
  logic [31:0] m_pc = RESET_PC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  initial begin : model
    bit  r, hs, resp, fault, nreq;
    wr_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_valid = 1'b1;
        exp_req     = 1'b0;
        m_out       = 1'b0;
        m_live      = 1'b0;
        m_halt      = 1'b0;
        m_pc        = RESET_PC;
      end else if (model_valid) begin
        r    = exp_req;
        hs   = r && inst_addr_ok;
        resp = inst_data_ok && m_out;
        // A request is shown while unaccepted, or one cycle after an idle cycle with room.
        nreq = !redirect_valid &&
               ((r && !inst_addr_ok) || (!r && !m_out && !m_halt && !fifo_full));
        if (redirect_valid) begin
          m_pc   = redirect_pc;
          m_halt = 1'b0;
          if (hs) begin
            m_out  = 1'b1;
            m_live = 1'b0;
          end else if (resp) begin
            m_out = 1'b0;
          end else if (m_out) begin
            m_live = 1'b0;
          end
        end else if (hs) begin
          m_out  = 1'b1;
          m_live = 1'b1;
        end else if (resp) begin
          m_out = 1'b0;
          if (m_live) begin
            fault = inst_tlb_refill || inst_tlb_invalid;
            e.en1 = 1'b1;
            e.a1  = m_pc;
            e.d1  = inst_rdata1;
            e.rf1 = inst_tlb_refill;
            e.iv1 = inst_tlb_invalid;
            e.en2 = !m_pc[2] && !fault;
            e.a2  = e.en2 ? m_pc + 32'd4 : 32'd0;
            e.d2  = e.en2 ? inst_rdata2 : 32'd0;
            exp_q.push_back(e);
            if (fault) m_halt = 1'b1;
            else       m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8;
          end
        end
        exp_req = nreq;
      end
    end
  end

  initial begin : monitor
    wr_t e;
    bit  v1, v2;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        if (exp_req) chk("inst_vaddr", inst_vaddr, m_pc);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          v1 = e.en1 && !redirect_valid;
          v2 = e.en2 && !redirect_valid;
          $display("cycle %0d write a1=%h en=%0d%0d flags=%0d%0d redirect=%0d",
                   cyc, e.a1, v1, v2, e.rf1, e.iv1, redirect_valid);
          chk("write_en1", 32'(write_en1), 32'(v1));
          chk("write_en2", 32'(write_en2), 32'(v2));
          if (v1) begin
            chk("write_address1", write_address1, e.a1);
            chk("write_data1", write_data1, e.d1);
            chk("write_tlb_refill1", 32'(write_tlb_refill1), 32'(e.rf1));
            chk("write_tlb_invalid1", 32'(write_tlb_invalid1), 32'(e.iv1));
          end
          if (v2 || !e.en2) begin
            chk("write_address2", write_address2, e.a2);
            chk("write_data2", write_data2, e.d2);
          end
          chk("write_slot2_flags", {30'd0, write_tlb_refill2, write_tlb_invalid2}, 32'd0);
        end else begin
          chk("idle_en", {30'd0, write_en1, write_en2}, 32'd0);
          chk("idle_addr", write_address1 | write_address2, 32'd0);
          chk("idle_data", write_data1 | write_data2, 32'd0);
          chk("idle_flags", {28'd0, write_tlb_refill1, write_tlb_invalid1,
                             write_tlb_refill2, write_tlb_invalid2}, 32'd0);
        end
      end
    end
  end

  // One clock of stimulus: the responder accepts a visible request with probability pa%
  // and returns an outstanding response with probability pd%.
  task automatic cycle(input bit r_i, input bit rd_i, input logic [31:0] rpc_i, input bit full_i,
                       input int pa, input int pd, input bit rf_i, input bit iv_i,
                       input bit force_d);
    rst              = r_i;
    redirect_valid   = rd_i;
    redirect_pc      = rpc_i;
    fifo_full        = full_i;
    inst_addr_ok     = (inst_req === 1'b1) && (int'($urandom_range(99)) < pa);
    inst_data_ok     = force_d || (m_out && (int'($urandom_range(99)) < pd));
    inst_rdata1      = $urandom;
    inst_rdata2      = $urandom;
    inst_tlb_refill  = rf_i;
    inst_tlb_invalid = iv_i;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit full_i, input int pa, input int pd);
    repeat (n) cycle(1'b0, 1'b0, 32'd0, full_i, pa, pd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic park();
    run(8, 1'b1, 100, 100);
  endtask

  task automatic redir(input logic [31:0] a, input bit full_i);
    cycle(1'b0, 1'b1, a, full_i, 100, 100, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : stimulus
    int          p;
    bit          rd;
    logic [31:0] a;

    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run(10, 1'b0, 100, 100);

    park();
    run(5, 1'b1, 100, 100);
    redir(32'h8000_0104, 1'b1);
    run(2, 1'b1, 100, 100);
    run(8, 1'b0, 100, 100);

    park();
    run(2, 1'b0, 100, 0);
    cycle(1'b0, 1'b1, 32'h8000_1000, 1'b0, 100, 0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 100, 0);
    run(8, 1'b0, 100, 100);

    park();
    run(2, 1'b0, 100, 0);
    cycle(1'b0, 1'b1, 32'h8000_2000, 1'b0, 100, 100, 1'b0, 1'b0, 1'b0);
    run(6, 1'b0, 100, 100);

    park();
    run(3, 1'b0, 100, 100);
    redir(32'h8000_3000, 1'b0);
    run(6, 1'b0, 100, 100);

    park();
    redir(32'h0040_0000, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0, 100, 100, 1'b1, 1'b0, 1'b0);
    run(6, 1'b0, 100, 100);
    redir(32'h0050_0000, 1'b0);
    run(6, 1'b0, 100, 100);

    park();
    redir(32'h0060_0004, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0, 100, 100, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 100, 100);
    redir(32'h0070_0000, 1'b0);
    run(6, 1'b0, 100, 100);

    park();
    redir(32'hFFFF_FFF8, 1'b1);
    run(10, 1'b0, 100, 100);

    park();
    run(2, 1'b0, 100, 0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    run(8, 1'b0, 100, 100);

    repeat (4000) begin
      p  = int'($urandom_range(999));
      rd = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) a = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
      else                        a = $urandom & 32'hFFFF_FFFC;
      cycle(p < 3, rd, a, $urandom_range(99) < 25, 60, 50,
            $urandom_range(99) < 4, $urandom_range(99) < 4, 1'b0);
    end
    run(4, 1'b0, 100, 100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction FIFO.
- Holds the fetch PC and issues one SRAM-like request at a time to the I-cache/TLB path. Each request fetches an 8-byte-aligned pair, or a single instruction when the PC is at an odd word.
- Forwards returned instructions, addresses and TLB fault flags to the FIFO write port.
- Handles redirects (branch, exception, eret) by cancelling in-flight responses. Stops fetching after a TLB fault until redirected.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC value loaded on reset.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
redirect_valid  in  1  flush fetch; same cycle as the FIFO's fifo_rst
redirect_pc  in  32  new fetch PC; word aligned
fifo_full  in  1  FIFO cannot accept two entries
inst_req  out  1  I-cache request valid
inst_vaddr  out  32  request address = current PC
inst_addr_ok  in  1  request accepted
inst_data_ok  in  1  response valid
inst_rdata1  in  32  instruction at inst_vaddr
inst_rdata2  in  32  instruction at inst_vaddr+4; ignored when PC[2]=1
inst_tlb_refill  in  1  response carries TLB refill fault
inst_tlb_invalid  in  1  response carries TLB invalid fault
write_en1, write_en2  out  1 each  FIFO slot writes
write_address1, write_address2  out  32 each  PCs of slots
write_data1, write_data2  out  32 each  instructions
write_tlb_refill1, write_tlb_refill2  out  1 each  fault flags per slot
write_tlb_invalid1, write_tlb_invalid2  out  1 each  fault flags per slot

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, inst_req=0, all write_* registers=0.
- State IDLE:
  - redirect_valid → pc=redirect_pc, stay IDLE.
  - else if !fifo_full → REQ.
- State REQ: inst_req=1, inst_vaddr=pc, both held stable until accepted.
  - addr_ok & !redirect → WAIT.
  - addr_ok & redirect → CANCEL, pc=redirect_pc.
  - !addr_ok & redirect → IDLE, pc=redirect_pc; inst_req drops for ≥1 cycle.
- State WAIT: inst_req=0.
  - data_ok & !redirect:
    - Capture the response into the output registers.
    - If no fault: pc={pc[31:3]+1,3'b000}, → IDLE.
    - If fault: → HALT, pc unchanged.
  - data_ok & redirect → response dropped, pc=redirect_pc, → IDLE.
  - !data_ok & redirect → CANCEL, pc=redirect_pc.
- State CANCEL: waits for the single outstanding response and discards it.
  - data_ok → IDLE (redirect in the same cycle updates pc).
  - redirect without data_ok → pc updated, stay CANCEL.
- State HALT: no requests; redirect → pc=redirect_pc, → IDLE.
- Capture rules:
  - write_en1=1, write_address1=pc, write_data1=rdata1.
  - write_en2=!pc[2] & !fault, write_address2=pc+4, write_data2=rdata2.
  - Fault flags go to slot 1 only; slot-2 flags are always 0.
  - write_en2=0 forces write_address2/write_data2 to 0.
- Output timing: write_* outputs are registered, 1 cycle after data_ok. They are held for exactly 1 cycle, then cleared.
- Redirect in the output cycle: visible write_en1/2 = reg & !redirect_valid, so pending data is killed.
- Throughput: at most one outstanding request. Minimum loop IDLE→REQ→WAIT→IDLE gives 3 cycles per pair with addr_ok and data_ok each in 1 cycle.
- Full handling: fifo_full is sampled only in IDLE. A single outstanding request (≤2 entries) is always accepted by the FIFO, because only this block writes it.
- Priority: rst > redirect_valid > data_ok/addr_ok > fifo_full.
- Arithmetic: pc increments are 32-bit, wrapping at 2^32 with no flag.

Test Plan:
- Reset, addr_ok and data_ok immediate: inst_vaddr=BFC00000. Next cycle write_en1=write_en2=1, addresses BFC00000/BFC00004. Next request to BFC00008.
- redirect_pc=80000104 from IDLE: request at 80000104, only write_en1=1 with write_address1=80000104. Next request to 80000108.
- Redirect in WAIT to 80001000, data_ok 2 cycles later: no write_en. Next inst_vaddr=80001000.
- Redirect in the same cycle as data_ok: write_en stays 0. Also: redirect in the cycle the registered write appears → write_en1=write_en2=0.
- Response with inst_tlb_refill=1 at pc=00400000: write_en1=1, write_tlb_refill1=1, write_en2=0. No inst_req until redirect; then resumes at redirect_pc.
- fifo_full=1 held 5 cycles in IDLE: inst_req stays 0. Deassert → inst_req=1 next cycle. Also: rst mid-WAIT → state IDLE, pc=BFC00000, a late data_ok is ignored.
